// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle MIPS core.
// Holds the FSM state set, opcode/funct codes, ALU ops and the control strobe bundle.
package mc_pkg;

    typedef enum logic [3:0] {
        RST, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC,
        ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP, JAL, HALT
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;

    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_SLT = 6'h2A;

    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_t;
    typedef enum logic [1:0] {SB_B, SB_IMM, SB_IMM4} srcb_t;
    typedef enum logic [1:0] {RD_RT, RD_RD, RD_R31} dst_t;
    typedef enum logic [1:0] {WB_ALU, WB_MDR, WB_PC} wb_t;

    typedef struct packed {
        logic    mem_req;
        logic    mem_we;
        logic    addr_alu;
        logic    ir_we;
        logic    pc_inc;
        logic    pc_br;
        logic    pc_jump;
        logic    mdr_we;
        logic    ab_we;
        logic    alu_we;
        logic    srca_pc;
        srcb_t   srcb;
        alu_op_t alu_op;
        logic    rf_we;
        dst_t    dst;
        wb_t     wb;
    } ctrl_t;

    function automatic logic funct_ok(input logic [5:0] f);
        return (f == F_ADD) || (f == F_SUB) || (f == F_AND) || (f == F_OR) || (f == F_SLT);
    endfunction

    function automatic alu_op_t funct_op(input logic [5:0] f);
        case (f)
            F_SUB:   return ALU_SUB;
            F_AND:   return ALU_AND;
            F_OR:    return ALU_OR;
            F_SLT:   return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mc_ctrl.sv
// Multicycle control FSM with memory-wait watchdog.
// Emits one-cycle datapath strobes; memory strobes are purely state-decoded so reset drops them at once.
module mc_ctrl
    import mc_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    input  logic       eq,
    output ctrl_t      ctl,
    output logic       halted,
    output logic       timeout_err
);

    state_t      state, state_nx;
    logic [31:0] wait_cnt;
    logic        mem_state, expire;

    assign mem_state = (state == FETCH) || (state == MEMRD) || (state == MEMWR);
    // A ready in the final allowed cycle still completes the access.
    assign expire    = (TIMEOUT != 0) && mem_state && !mem_ready && (wait_cnt == 32'(TIMEOUT));
    assign halted    = (state == HALT);

    always_comb begin
        state_nx = state;
        ctl      = '0;
        case (state)
            RST: state_nx = FETCH;
            FETCH: begin
                ctl.mem_req = 1'b1;
                if (mem_ready) begin
                    ctl.ir_we  = 1'b1;
                    ctl.pc_inc = 1'b1;
                    state_nx   = DECODE;
                end
            end
            DECODE: begin
                ctl.ab_we   = 1'b1;
                ctl.alu_we  = 1'b1;
                ctl.srca_pc = 1'b1;
                ctl.srcb    = SB_IMM4;
                case (op)
                    OP_LW, OP_SW:   state_nx = MEMADR;
                    OP_RTYPE:       state_nx = funct_ok(funct) ? EXEC : HALT;
                    OP_BEQ, OP_BNE: state_nx = BRANCH;
                    OP_ADDI:        state_nx = ADDIEX;
                    OP_J:           state_nx = JUMP;
                    OP_JAL:         state_nx = JAL;
                    default:        state_nx = HALT;
                endcase
            end
            MEMADR: begin
                ctl.alu_we = 1'b1;
                ctl.srcb   = SB_IMM;
                state_nx   = (op == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                ctl.mem_req  = 1'b1;
                ctl.addr_alu = 1'b1;
                if (mem_ready) begin
                    ctl.mdr_we = 1'b1;
                    state_nx   = MEMWB;
                end
            end
            MEMWB: begin
                ctl.rf_we = 1'b1;
                ctl.dst   = RD_RT;
                ctl.wb    = WB_MDR;
                state_nx  = FETCH;
            end
            MEMWR: begin
                ctl.mem_req  = 1'b1;
                ctl.mem_we   = 1'b1;
                ctl.addr_alu = 1'b1;
                if (mem_ready) state_nx = FETCH;
            end
            EXEC: begin
                ctl.alu_we = 1'b1;
                ctl.alu_op = funct_op(funct);
                state_nx   = ALUWB;
            end
            ALUWB: begin
                ctl.rf_we = 1'b1;
                ctl.dst   = RD_RD;
                state_nx  = FETCH;
            end
            BRANCH: begin
                ctl.pc_br = eq ^ (op == OP_BNE);
                state_nx  = FETCH;
            end
            ADDIEX: begin
                ctl.alu_we = 1'b1;
                ctl.srcb   = SB_IMM;
                state_nx   = ADDIWB;
            end
            ADDIWB: begin
                ctl.rf_we = 1'b1;
                ctl.dst   = RD_RT;
                state_nx  = FETCH;
            end
            JUMP: begin
                ctl.pc_jump = 1'b1;
                state_nx    = FETCH;
            end
            JAL: begin
                ctl.pc_jump = 1'b1;
                ctl.rf_we   = 1'b1;
                ctl.dst     = RD_R31;
                ctl.wb      = WB_PC;
                state_nx    = FETCH;
            end
            default: state_nx = HALT;
        endcase
        if (expire) state_nx = HALT;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= RST;
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            state <= state_nx;
            if (state_nx != state)
                wait_cnt <= '0;
            else if (mem_state && !mem_ready)
                wait_cnt <= wait_cnt + 32'd1;
            if (expire) timeout_err <= 1'b1;
        end
    end

endmodule

// File: rtl/mc_core.sv
// Multicycle MIPS core: datapath, register file and ALU around the mc_ctrl FSM.
// Talks to one unified instruction/data memory through a req/ready handshake.
module mc_core
    import mc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] pc,
    output logic        halted,
    output logic        timeout_err
);

    ctrl_t       ctl;
    logic [31:0] ir, mdr, a, b, aluout;
    logic [31:0] rf [32];
    logic [31:0] signimm, rd_a, rd_b, srca, srcb, alu_y, jtarget, wdata;
    logic [4:0]  waddr;

    mc_ctrl #(.TIMEOUT(TIMEOUT)) u_ctrl (
        .clk         (clk),
        .reset       (reset),
        .op          (ir[31:26]),
        .funct       (ir[5:0]),
        .mem_ready   (mem_ready),
        .eq          (a == b),
        .ctl         (ctl),
        .halted      (halted),
        .timeout_err (timeout_err)
    );

    assign signimm = {{16{ir[15]}}, ir[15:0]};
    assign rd_a    = (ir[25:21] == 5'd0) ? 32'd0 : rf[ir[25:21]];
    assign rd_b    = (ir[20:16] == 5'd0) ? 32'd0 : rf[ir[20:16]];
    assign srca    = ctl.srca_pc ? pc : a;
    // pc here is already pc+4 of the jumping instruction
    assign jtarget = {pc[31:28], ir[25:0], 2'b00};

    always_comb begin
        case (ctl.srcb)
            SB_IMM:  srcb = signimm;
            SB_IMM4: srcb = {signimm[29:0], 2'b00};
            default: srcb = b;
        endcase
        case (ctl.alu_op)
            ALU_SUB: alu_y = srca - srcb;
            ALU_AND: alu_y = srca & srcb;
            ALU_OR:  alu_y = srca | srcb;
            ALU_SLT: alu_y = {31'd0, $signed(srca) < $signed(srcb)};
            default: alu_y = srca + srcb;
        endcase
        case (ctl.dst)
            RD_RD:   waddr = ir[15:11];
            RD_R31:  waddr = 5'd31;
            default: waddr = ir[20:16];
        endcase
        case (ctl.wb)
            WB_MDR:  wdata = mdr;
            WB_PC:   wdata = pc;
            default: wdata = aluout;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc     <= RESET_PC;
            ir     <= '0;
            mdr    <= '0;
            a      <= '0;
            b      <= '0;
            aluout <= '0;
        end else begin
            if (ctl.pc_inc)       pc <= pc + 32'd4;
            else if (ctl.pc_br)   pc <= aluout;
            else if (ctl.pc_jump) pc <= jtarget;
            if (ctl.ir_we)  ir  <= mem_rdata;
            if (ctl.mdr_we) mdr <= mem_rdata;
            if (ctl.ab_we) begin
                a <= rd_a;
                b <= rd_b;
            end
            if (ctl.alu_we) aluout <= alu_y;
        end
    end

    always_ff @(posedge clk) begin
        if (ctl.rf_we && (waddr != 5'd0)) rf[waddr] <= wdata;
    end

    assign mem_req   = ctl.mem_req;
    assign mem_we    = ctl.mem_we;
    assign mem_addr  = {(ctl.addr_alu ? aluout[31:2] : pc[31:2]), 2'b00};
    assign mem_wdata = b;

endmodule

// File: tb/tb_mc_core.sv
// Directed bench for mc_core: a table of instructions with hand-computed cycle counts,
// next-pc and store results, plus hand sequences for reset, illegal opcode and watchdog.
module tb_mc_core;

    localparam logic [5:0] OPR = 6'h00, OLW = 6'h23, OSW = 6'h2B, OBEQ = 6'h04,
                           OBNE = 6'h05, OADDI = 6'h08, OJ = 6'h02, OJAL = 6'h03;
    localparam logic [5:0] FADD = 6'h20, FSUB = 6'h22, FAND = 6'h24, FOR = 6'h25, FSLT = 6'h2A;
    localparam logic [31:0] ILLEGAL = 32'hFC00_0000;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        int          cyc;
        logic [31:0] nxt;
        bit          wr;
        logic [31:0] wa;
        logic [31:0] wd;
        int          waits;
    } vec_t;

    logic        clk, reset;
    logic        mem_req, mem_we, mem_ready, halted, timeout_err;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;

    logic [31:0] mem [512];
    logic        ld_en, fetch_block;
    logic [8:0]  ld_addr;
    logic [31:0] ld_data, wr_addr, wr_data;
    int          wr_cnt, stall_cnt, rd_waits;
    int          n_chk, n_pass;
    logic        data_access, fetch_now;

    mc_core #(.RESET_PC(32'h100), .TIMEOUT(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready),
        .pc          (pc),
        .halted      (halted),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: instruction fetches are zero-wait, data accesses wait rd_waits cycles.
    assign fetch_now   = mem_req && !mem_we && (mem_addr == pc);
    assign data_access = mem_req && (mem_we || (mem_addr != pc));
    assign mem_ready   = fetch_block ? 1'b0 : (!data_access || (stall_cnt >= rd_waits));
    assign mem_rdata   = mem[mem_addr[10:2]];

    always @(posedge clk) begin
        if (ld_en)
            mem[ld_addr] <= ld_data;
        else if (mem_req && mem_we && mem_ready) begin
            mem[mem_addr[10:2]] <= mem_wdata;
            wr_cnt  <= wr_cnt + 1;
            wr_addr <= mem_addr;
            wr_data <= mem_wdata;
        end
        if (data_access && !mem_ready) stall_cnt <= stall_cnt + 1;
        else                           stall_cnt <= 0;
    end

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] f);
        return {OPR, 5'(rs), 5'(rt), 5'(rd), 5'd0, f};
    endfunction
    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction
    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] t);
        return {op, t};
    endfunction
    function automatic vec_t mk(input logic [31:0] addr, input logic [31:0] instr, input int cyc,
                                input logic [31:0] nxt, input bit wr, input logic [31:0] wa,
                                input logic [31:0] wd, input int waits);
        vec_t r;
        r.addr = addr; r.instr = instr; r.cyc = cyc; r.nxt = nxt;
        r.wr = wr; r.wa = wa; r.wd = wd; r.waits = waits;
        return r;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", nm, act, exp);
    endtask

    task automatic load(input logic [31:0] addr, input logic [31:0] w);
        ld_en   = 1'b1;
        ld_addr = addr[10:2];
        ld_data = w;
        @(negedge clk);
        ld_en   = 1'b0;
    endtask

    // Entered on the negedge where v's fetch is first presented; leaves on the next fetch.
    task automatic run_insn(input vec_t v, input int idx);
        int          cyc, wr0;
        bit          done, prev_fetch, prev_req, prev_we;
        logic [31:0] prev_addr;
        rd_waits = v.waits;
        check($sformatf("fetch_addr[%0d]", idx), mem_addr, v.addr);
        wr0 = wr_cnt; cyc = 1; done = 0;
        prev_fetch = fetch_now; prev_req = mem_req; prev_addr = mem_addr; prev_we = mem_we;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (k == 0) check($sformatf("pc_inc[%0d]", idx), pc, v.addr + 32'd4);
            if (fetch_now && !prev_fetch) done = 1;
            else begin
                cyc++;
                if (mem_req && prev_req) begin
                    check($sformatf("hold_addr[%0d]", idx), mem_addr, prev_addr);
                    check($sformatf("hold_we[%0d]", idx), 32'(mem_we), 32'(prev_we));
                end
            end
            prev_fetch = fetch_now; prev_req = mem_req; prev_addr = mem_addr; prev_we = mem_we;
        end
        if (!done) begin
            n_chk++;
            $display("FAIL next_fetch[%0d]: no fetch within 40 cycles, want one", idx);
        end else begin
            check($sformatf("cycles[%0d]", idx), 32'(cyc), 32'(v.cyc));
            check($sformatf("next_pc[%0d]", idx), pc, v.nxt);
        end
        if (v.wr) begin
            check($sformatf("wr_cnt[%0d]", idx), 32'(wr_cnt), 32'(wr0 + 1));
            check($sformatf("wr_addr[%0d]", idx), wr_addr, v.wa);
            check($sformatf("wr_data[%0d]", idx), wr_data, v.wd);
        end else begin
            check($sformatf("no_wr[%0d]", idx), 32'(wr_cnt), 32'(wr0));
        end
    endtask

    localparam int NV = 29;
    vec_t tv [NV];

    initial begin
        n_chk = 0; n_pass = 0; wr_cnt = 0; stall_cnt = 0; rd_waits = 0;
        reset = 1'b0; fetch_block = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        wr_addr = '0; wr_data = '0;

        tv[0]  = mk(32'h100, enc_i(OADDI, 0, 1, 16'd5),     4, 32'h104, 0, 0, 0, 0);
        tv[1]  = mk(32'h104, enc_i(OADDI, 0, 2, 16'd7),     4, 32'h108, 0, 0, 0, 0);
        tv[2]  = mk(32'h108, enc_r(1, 2, 3, FADD),          4, 32'h10C, 0, 0, 0, 0);
        tv[3]  = mk(32'h10C, enc_i(OSW, 0, 3, 16'd8),       4, 32'h110, 1, 32'h08, 32'd12, 0);
        tv[4]  = mk(32'h110, enc_i(OLW, 0, 4, 16'd8),       5, 32'h114, 0, 0, 0, 0);
        tv[5]  = mk(32'h114, enc_i(OSW, 0, 4, 16'd12),      4, 32'h118, 1, 32'h0C, 32'd12, 0);
        tv[6]  = mk(32'h118, enc_r(1, 2, 5, FSUB),          4, 32'h11C, 0, 0, 0, 0);
        tv[7]  = mk(32'h11C, enc_i(OSW, 0, 5, 16'd16),      4, 32'h120, 1, 32'h10, 32'hFFFF_FFFE, 0);
        tv[8]  = mk(32'h120, enc_r(5, 1, 6, FSLT),          4, 32'h124, 0, 0, 0, 0);
        tv[9]  = mk(32'h124, enc_i(OSW, 0, 6, 16'd20),      4, 32'h128, 1, 32'h14, 32'd1, 0);
        tv[10] = mk(32'h128, enc_r(1, 2, 7, FAND),          4, 32'h12C, 0, 0, 0, 0);
        tv[11] = mk(32'h12C, enc_i(OSW, 0, 7, 16'd24),      4, 32'h130, 1, 32'h18, 32'd5, 0);
        tv[12] = mk(32'h130, enc_r(1, 2, 8, FOR),           4, 32'h134, 0, 0, 0, 0);
        tv[13] = mk(32'h134, enc_i(OSW, 0, 8, 16'd28),      4, 32'h138, 1, 32'h1C, 32'd7, 0);
        tv[14] = mk(32'h138, enc_r(1, 5, 9, FSLT),          4, 32'h13C, 0, 0, 0, 0);
        tv[15] = mk(32'h13C, enc_i(OSW, 0, 9, 16'd32),      4, 32'h140, 1, 32'h20, 32'd0, 0);
        tv[16] = mk(32'h140, enc_i(OBEQ, 1, 2, 16'd2),      3, 32'h144, 0, 0, 0, 0);
        tv[17] = mk(32'h144, enc_i(OBNE, 1, 2, 16'd2),      3, 32'h150, 0, 0, 0, 0);
        tv[18] = mk(32'h150, enc_i(OADDI, 0, 10, 16'hFFFD), 4, 32'h154, 0, 0, 0, 0);
        tv[19] = mk(32'h154, enc_i(OSW, 0, 10, 16'd36),     4, 32'h158, 1, 32'h24, 32'hFFFF_FFFD, 0);
        tv[20] = mk(32'h158, enc_i(OBNE, 1, 1, 16'd5),      3, 32'h15C, 0, 0, 0, 0);
        tv[21] = mk(32'h15C, enc_i(OBEQ, 2, 2, 16'd1),      3, 32'h164, 0, 0, 0, 0);
        tv[22] = mk(32'h164, enc_j(OJ, 26'h10),             3, 32'h040, 0, 0, 0, 0);
        tv[23] = mk(32'h040, enc_j(OJAL, 26'h80),           3, 32'h200, 0, 0, 0, 0);
        tv[24] = mk(32'h200, enc_i(OSW, 0, 31, 16'd40),     4, 32'h204, 1, 32'h28, 32'h44, 0);
        tv[25] = mk(32'h204, enc_r(1, 2, 0, FADD),          4, 32'h208, 0, 0, 0, 0);
        tv[26] = mk(32'h208, enc_i(OSW, 0, 0, 16'd44),      4, 32'h20C, 1, 32'h2C, 32'd0, 0);
        tv[27] = mk(32'h20C, enc_i(OLW, 0, 11, 16'd8),      8, 32'h210, 0, 0, 0, 3);
        tv[28] = mk(32'h210, enc_i(OSW, 0, 11, 16'd48),     4, 32'h214, 1, 32'h30, 32'd12, 0);

        @(negedge clk);
        for (int i = 0; i < NV; i++) load(tv[i].addr, tv[i].instr);
        load(32'h148, ILLEGAL);
        load(32'h14C, ILLEGAL);
        load(32'h160, ILLEGAL);
        load(32'h214, ILLEGAL);

        check("rst_pc", pc, 32'h100);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", mem_addr, 32'h100);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);

        reset = 1'b1;
        @(negedge clk);
        check("first_fetch_req", 32'(mem_req), 32'd1);
        for (int i = 0; i < NV; i++) run_insn(tv[i], i);

        // Illegal opcode at 0x214: FETCH, DECODE, then HALT.
        check("ill_fetch", mem_addr, 32'h214);
        @(negedge clk);
        @(negedge clk);
        check("ill_halted", 32'(halted), 32'd1);
        check("ill_timeout_err", 32'(timeout_err), 32'd0);
        check("ill_mem_req", 32'(mem_req), 32'd0);
        check("ill_pc", pc, 32'h218);
        repeat (3) @(negedge clk);
        check("ill_absorb", 32'(halted), 32'd1);

        // Watchdog: fetch never completes. First abort a stalled fetch with a mid-cycle reset.
        fetch_block = 1'b1;
        reset = 1'b0;
        @(negedge clk);
        check("rst2_halted", 32'(halted), 32'd0);
        check("rst2_pc", pc, 32'h100);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("stall_req", 32'(mem_req), 32'd1);
        reset = 1'b0;
        #1;
        check("async_abort_req", 32'(mem_req), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        check("wd_not_yet", 32'(halted), 32'd0);
        check("wd_still_req", 32'(mem_req), 32'd1);
        @(negedge clk);
        check("wd_halted", 32'(halted), 32'd1);
        check("wd_timeout_err", 32'(timeout_err), 32'd1);
        check("wd_mem_req", 32'(mem_req), 32'd0);
        repeat (3) @(negedge clk);
        check("wd_absorb", 32'(halted), 32'd1);
        check("wd_absorb_req", 32'(mem_req), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mc_core.md
# mc_core

Parametrised multicycle MIPS core with an integrated control FSM, a unified single-port memory interface with a ready/wait handshake, and a memory-timeout watchdog. It merges the multicycle datapath and its controller into one block. It adds `bne`, `jal` and wait-state tolerance, and sits directly between the testbench/top level and a unified instruction/data memory.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, address of the first instruction fetch.
- TIMEOUT, 255, maximum consecutive cycles a memory request may wait for mem_ready. 0 disables the watchdog.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low (0 = in reset).
- mem_req  out  1  memory access requested this cycle.
- mem_we  out  1  request is a write (valid only with mem_req).
- mem_addr  out  32  byte address; bits [1:0] always 0.
- mem_wdata  out  32  store data.
- mem_rdata  in  32  read data; valid in the cycle mem_ready=1.
- mem_ready  in  1  access completes this cycle.
- pc  out  32  current program counter.
- halted  out  1  core stopped (illegal opcode or timeout).
- timeout_err  out  1  halt cause was watchdog expiry.

## Operation
- Registers: pc, IR, MDR, A, B, ALUOut; 32x32 register file.
- Register file: $0 reads 0 and ignores writes; 2 async read ports, 1 sync write port; not reset.
- Instructions: lw, sw, R-type (add, sub, and, or, slt), beq, bne, addi, j, jal.
- Any other opcode or funct goes to HALT.
- ALU is 32-bit two's complement; overflow ignored.
- slt is signed and yields 0 or 1.
- Immediates are sign-extended. Branch offset is signimm<<2.
- Jump target: {pc[31:28], IR[25:0], 2'b00}, where pc is already incremented.

State machine (states listed in the package):
- RST: entered while in reset; next cycle → FETCH.
- FETCH: mem_req=1, mem_addr=pc. On mem_ready: IR←mem_rdata, pc←pc+4, go to DECODE.
- DECODE: A←rf[rs], B←rf[rt], ALUOut←pc+(signimm<<2). Then dispatch:
  - lw/sw → MEMADR
  - R → EXEC
  - beq/bne → BRANCH
  - addi → ADDIEX
  - j → JUMP
  - jal → JAL
  - else → HALT
- MEMADR: ALUOut←A+signimm; lw → MEMRD, sw → MEMWR.
- MEMRD: mem_req=1, addr=ALUOut. On mem_ready: MDR←mem_rdata, go to MEMWB.
- MEMWB: rf[rt]←MDR, go to FETCH.
- MEMWR: mem_req=1, mem_we=1, addr=ALUOut, wdata=B. On mem_ready, go to FETCH.
- EXEC: ALUOut←A op B, go to ALUWB.
- ALUWB: rf[rd]←ALUOut, go to FETCH.
- BRANCH: compute A−B. If (zero XOR bne), pc←ALUOut. Go to FETCH.
- ADDIEX: ALUOut←A+signimm, go to ADDIWB.
- ADDIWB: rf[rt]←ALUOut, go to FETCH.
- JUMP: pc←target, go to FETCH.
- JAL: rf[31]←pc, pc←target, go to FETCH.
- HALT: absorbing until reset. halted=1 and mem_req=0.

Watchdog:
- A wait counter clears on entry to any memory state and increments each cycle mem_ready=0 within that state.
- When TIMEOUT≠0 and the counter reaches TIMEOUT with mem_ready still 0, go to HALT with timeout_err←1.
- mem_ready=1 in that same cycle wins; no timeout is raised.

## Timing
- Reset values: pc=RESET_PC, mem_req=0, mem_we=0, mem_addr=RESET_PC, mem_wdata=0, halted=0, timeout_err=0, state=RST. IR, MDR, A, B and ALUOut are 0.
- Reset assertion mid-instruction aborts immediately: mem_req drops asynchronously. Register file contents are undefined afterwards.
- Handshake: while mem_req=1, mem_addr, mem_we and mem_wdata are held stable until the cycle mem_ready=1. mem_ready while mem_req=0 is ignored.
- Zero-wait cycle counts, FETCH through return to FETCH:
  - lw: 5
  - sw: 4
  - R-type: 4
  - addi: 4
  - beq/bne: 3
  - j: 3
  - jal: 3
- Each wait cycle in FETCH, MEMRD or MEMWR adds 1.
- pc wraps modulo 2^32 with no flag.
- Register write takes effect at the end of the writeback cycle. The next instruction's DECODE sees the new value.

## Structure
- Package mc_pkg holds:
  - state_t enum (RST…HALT)
  - opcode/funct localparams (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J, OP_JAL; F_ADD, F_SUB, F_AND, F_OR, F_SLT)
  - alu_op_t enum
- Sub-module mc_ctrl: the FSM plus watchdog counter. It produces decoded control strobes.
- mc_core keeps the datapath, register file and ALU.

## Test plan
- Reset release with RESET_PC=32'h100 and zero-wait memory → first mem_addr=32'h100 on the second cycle after deassert; pc=32'h104 after FETCH.
- Program `addi $1,$0,5; addi $2,$0,7; add $3,$1,$2; sw $3,8($0); lw $4,8($0)` → write of 12 to address 8; $4=12; total 4+4+4+4+5 cycles.
- bne $1,$2,+2 with unequal values → pc=old_pc+4+8 after 3 cycles. beq on the same operands → no branch.
- jal at pc=32'h40 to target 32'h200 → $31=32'h44, pc=32'h200, 3 cycles.
- mem_ready held low with 3 wait cycles in MEMRD → lw takes 8 cycles; address and we remain stable throughout.
- TIMEOUT=4 and mem_ready never asserted in FETCH → halted=1 and timeout_err=1, mem_req=0 afterwards. Illegal opcode 6'h3F → halted=1, timeout_err=0.
